// File: rtl/marble_dispenser.sv
// Marble source for the top ramp: edge-detects start buttons and bottom levers, releases one marble per request.
// Latency: a request edge sampled at edge N gives a one-cycle o_blue/o_red pulse from edge N; counts update at edge N.
// No backpressure: requests outside IDLE/FLIGHT are dropped, and i_halt freezes the block until reset.
module marble_dispenser #(
  parameter int BLUE_COUNT = 8,
  parameter int RED_COUNT  = 8,
  parameter int CNT_W      = 5,
  parameter int TIMEOUT    = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start_blue,
  input  logic             i_start_red,
  input  logic             i_trig_left,
  input  logic             i_trig_right,
  input  logic             i_halt,
  output logic             o_blue,
  output logic             o_red,
  output logic [CNT_W-1:0] o_blue_left,
  output logic [CNT_W-1:0] o_red_left,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_empty,
  output logic             o_lost,
  output logic             o_conflict
);

  // Flight counter only needs to reach TIMEOUT-1; one spare bit keeps small TIMEOUT values safe.
  localparam int              FC_W    = $clog2(TIMEOUT) + 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RELEASE = 2'd1,
    S_FLIGHT  = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              color_blue;
  logic              next_color_blue;
  logic [FC_W-1:0]   flight_cnt;

  logic prev_start_blue;
  logic prev_start_red;
  logic prev_trig_left;
  logic prev_trig_right;

  logic ev_start_blue;
  logic ev_start_red;
  logic ev_trig_left;
  logic ev_trig_right;

  logic req_vld;
  logic req_blue;
  logic dec_blue;
  logic dec_red;
  logic set_empty;
  logic set_lost;
  logic set_conflict;

  assign ev_start_blue = i_start_blue & ~prev_start_blue;
  assign ev_start_red  = i_start_red  & ~prev_start_red;
  assign ev_trig_left  = i_trig_left  & ~prev_trig_left;
  assign ev_trig_right = i_trig_right & ~prev_trig_right;

  // Previous-sample registers for rising-edge detection; cleared so inputs held through reset fire once.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_start_blue <= 1'b0;
      prev_start_red  <= 1'b0;
      prev_trig_left  <= 1'b0;
      prev_trig_right <= 1'b0;
    end else begin
      prev_start_blue <= i_start_blue;
      prev_start_red  <= i_start_red;
      prev_trig_left  <= i_trig_left;
      prev_trig_right <= i_trig_right;
    end
  end

  // Next-state decision: pick the request source per state, resolve it against the reservoir, halt overrides all.
  always_comb begin
    next_state      = state;
    next_color_blue = color_blue;
    req_vld         = 1'b0;
    req_blue        = 1'b0;
    dec_blue        = 1'b0;
    dec_red         = 1'b0;
    set_empty       = 1'b0;
    set_lost        = 1'b0;
    set_conflict    = 1'b0;

    case (state)
      S_IDLE: begin
        req_vld  = ev_start_blue | ev_start_red;
        req_blue = ev_start_blue;
      end
      S_RELEASE: begin
        next_state = S_FLIGHT;
      end
      S_FLIGHT: begin
        req_vld      = ev_trig_left | ev_trig_right;
        req_blue     = ev_trig_left;
        set_conflict = ev_trig_left & ev_trig_right;
        // A lever event on the last flight cycle wins over the timeout.
        if (!req_vld && (flight_cnt == FC_LAST)) begin
          set_lost   = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_HALTED;
      end
    endcase

    if (req_vld) begin
      if (req_blue) begin
        if (o_blue_left != '0) begin
          dec_blue        = 1'b1;
          next_state      = S_RELEASE;
          next_color_blue = 1'b1;
        end else begin
          set_empty  = 1'b1;
          next_state = S_IDLE;
        end
      end else begin
        if (o_red_left != '0) begin
          dec_red         = 1'b1;
          next_state      = S_RELEASE;
          next_color_blue = 1'b0;
        end else begin
          set_empty  = 1'b1;
          next_state = S_IDLE;
        end
      end
    end

    // The interceptor wins over everything, including a release that would start this cycle.
    if (i_halt) begin
      next_state   = S_HALTED;
      dec_blue     = 1'b0;
      dec_red      = 1'b0;
      set_empty    = 1'b0;
      set_lost     = 1'b0;
      set_conflict = 1'b0;
    end
  end

  // State, latched colour and flight counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      color_blue <= 1'b0;
      flight_cnt <= '0;
    end else begin
      state      <= next_state;
      color_blue <= next_color_blue;
      if (state == S_RELEASE) begin
        flight_cnt <= '0;
      end else if (state == S_FLIGHT) begin
        flight_cnt <= flight_cnt + 1'b1;
      end
    end
  end

  // Reservoir counts and sticky status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_blue_left <= CNT_W'(BLUE_COUNT);
      o_red_left  <= CNT_W'(RED_COUNT);
      o_empty     <= 1'b0;
      o_lost      <= 1'b0;
      o_conflict  <= 1'b0;
    end else begin
      if (dec_blue) o_blue_left <= o_blue_left - 1'b1;
      if (dec_red)  o_red_left  <= o_red_left - 1'b1;
      if (set_empty)    o_empty    <= 1'b1;
      if (set_lost)     o_lost     <= 1'b1;
      if (set_conflict) o_conflict <= 1'b1;
    end
  end

  // Registered view of the next state: release pulses, busy and halted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_blue   <= 1'b0;
      o_red    <= 1'b0;
      o_busy   <= 1'b0;
      o_halted <= 1'b0;
    end else begin
      o_blue   <= (next_state == S_RELEASE) &&  next_color_blue;
      o_red    <= (next_state == S_RELEASE) && !next_color_blue;
      o_busy   <= (next_state == S_RELEASE) || (next_state == S_FLIGHT);
      o_halted <= (next_state == S_HALTED);
    end
  end

endmodule
